// File: rtl/mc_controller.sv
// Multi-cycle RV32 control FSM: sequences lw/sw/R/I/beq/jal over a shared memory and ALU.
// Optional MC_MEMREADY_EN adds a memready handshake that stalls FETCH, MEMREAD and MEMWRITE.
module mc_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MC_MEMREADY_EN
    input  logic       memready,
`endif
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic       regwrite,
    output logic [2:0] aluctrl,
    output logic       halted,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_mem_ok;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic [1:0] w_aluop;
    logic [2:0] w_funct_ctrl;

`ifdef MC_MEMREADY_EN
    assign w_mem_ok = memready;
`else
    assign w_mem_ok = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: each always_comb assigns a default first so no path leaves a signal unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (w_mem_ok) w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_mem_ok) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (w_mem_ok) w_next_state = S_FETCH;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_HALT:     w_next_state = S_HALT;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Memory-state enables fold in memready so a stalled access never commits.
    always_comb begin
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_aluop    = ALUOP_ADD;
        adrsrc     = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwrite  = w_mem_ok;
                w_pcupdate = w_mem_ok;
                alusrcb    = 2'b10;
                resultsrc  = 2'b10;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: adrsrc = 1'b1;
            S_MEMWB: begin
                resultsrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                w_memwrite = w_mem_ok;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                w_aluop = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                w_aluop = ALUOP_FUNCT;
            end
            S_ALUWB:    w_regwrite = 1'b1;
            S_BEQ: begin
                alusrca  = 2'b10;
                w_aluop  = ALUOP_SUB;
                w_branch = 1'b1;
            end
            S_JAL: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_HALT:     halted = 1'b1;
            default:    halted = 1'b0;
        endcase
    end

    always_comb begin
        w_funct_ctrl = 3'b000;
        case (funct3)
            3'b000:  w_funct_ctrl = ((opcode == OP_R) && funct7) ? 3'b001 : 3'b000;
            3'b010:  w_funct_ctrl = 3'b101;
            3'b110:  w_funct_ctrl = 3'b011;
            3'b111:  w_funct_ctrl = 3'b010;
            default: w_funct_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        aluctrl = 3'b000;
        case (w_aluop)
            ALUOP_SUB:   aluctrl = 3'b001;
            ALUOP_FUNCT: aluctrl = w_funct_ctrl;
            default:     aluctrl = 3'b000;
        endcase
    end

    always_comb begin
        immsrc = 2'b00;
        case (opcode)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // Reset forces FETCH combinationally; the enables are masked so nothing commits during it.
    assign pcwrite  = ~reset & (w_pcupdate | (w_branch & zero));
    assign irwrite  = ~reset & w_irwrite;
    assign memwrite = ~reset & w_memwrite;
    assign regwrite = ~reset & w_regwrite;
    assign state    = r_state;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM for the RV32 core; replaces the single-cycle control/ALU-decode path when the core shares one memory and one ALU across cycles.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives mux selects, write enables, immediate select and the 3-bit ALU control.
- Retires one instruction every 3-5 cycles.

Parameters:
- HALT_ON_ILLEGAL, 1, 1 = unsupported opcode enters HALT; 0 = unsupported opcode returns to FETCH and is treated as a NOP.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state to FETCH
- opcode  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7  input  1  instr[30]
- zero  input  1  ALU zero flag
- pcwrite  output  1  PC register enable
- adrsrc  output  1  memory address select: 0 = PC, 1 = result
- memwrite  output  1  data memory write enable
- irwrite  output  1  IR and oldPC load enable
- resultsrc  output  2  result select: 00 = aluout, 01 = memdata, 10 = aluresult
- alusrca  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rd1
- alusrcb  output  2  ALU B select: 00 = rd2, 01 = imm, 10 = constant 4
- immsrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- regwrite  output  1  register file write enable
- aluctrl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- halted  output  1  high while in HALT
- state  output  4  current state code, for debug

Behaviour:
- Moore FSM. All outputs decode combinationally from the state register, except:
  - pcwrite = pcupdate | (branch & zero)
  - immsrc and aluctrl, which also decode from opcode/funct.
- Reset is asynchronous: state = FETCH (code 0). After reset deasserts, the first FETCH cycle asserts irwrite = 1, pcwrite = 1.
- Every control output not listed for a state is 0 in that state.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11.
- Per-state outputs and next state:
  - FETCH: adrsrc = 0, irwrite = 1, alusrca = 00, alusrcb = 10, aluop = add, resultsrc = 10, pcupdate = 1. Next: DECODE.
  - DECODE: alusrca = 01, alusrcb = 01, aluop = add (branch target into aluout). Next by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - other → HALT if HALT_ON_ILLEGAL, else FETCH
  - MEMADR: alusrca = 10, alusrcb = 01, aluop = add. Next: MEMREAD if opcode is lw, MEMWRITE if sw.
  - MEMREAD: adrsrc = 1, resultsrc = 00. Next: MEMWB.
  - MEMWB: resultsrc = 01, regwrite = 1. Next: FETCH.
  - MEMWRITE: adrsrc = 1, resultsrc = 00, memwrite = 1. Next: FETCH.
  - EXECUTER: alusrca = 10, alusrcb = 00, aluop = funct. Next: ALUWB.
  - EXECUTEI: alusrca = 10, alusrcb = 01, aluop = funct. Next: ALUWB.
  - ALUWB: resultsrc = 00, regwrite = 1. Next: FETCH.
  - BEQ: alusrca = 10, alusrcb = 00, aluop = sub, resultsrc = 00, branch = 1. Next: FETCH.
  - JAL: alusrca = 01, alusrcb = 10, aluop = add, resultsrc = 00, pcupdate = 1. Next: ALUWB (writes rd = PC + 4).
  - HALT: halted = 1; all enables 0. Stays in HALT until reset.
- ALU decode:
  - aluop add → 000; aluop sub → 001.
  - aluop funct, by funct3:
    - 000 → 001 only when opcode is R-type and funct7 = 1; otherwise 000
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - other → 000
- immsrc decodes from opcode in every state:
  - sw → 01; beq → 10; jal → 11; else 00.
- Cycle counts: lw 5, sw 4, R/I 4, beq 3, jal 4.
- opcode is sampled only in DECODE and MEMADR; IR stability is guaranteed by irwrite = 0 outside FETCH.
- Reset asserted mid-instruction aborts it immediately; no write enable may be high while reset is high.

Optional Feature:
- MC_MEMREADY_EN: adds input memready (1 bit).
  - In FETCH, MEMREAD and MEMWRITE the FSM holds state while memready = 0.
  - While held, the state's select outputs stay driven but irwrite, pcwrite and memwrite are gated to 0.
  - The enables fire in the cycle memready = 1, and the FSM advances in that same cycle.
- Without the macro: no memready port; every memory state takes exactly one cycle.

Test Plan:
- Reset asserted mid-EXECUTER → state = 0 asynchronously; after release, FETCH shows irwrite = 1, pcwrite = 1.
- lw (opcode 0000011) → states 0,1,2,3,4,0; regwrite = 1 only in MEMWB with resultsrc = 01; immsrc = 00.
- R-type sub (funct3 = 000, funct7 = 1) → aluctrl = 001 in EXECUTER. Same funct3/funct7 on an I-type addi → aluctrl = 000.
- beq with zero = 1 → pcwrite = 1 in BEQ, aluctrl = 001. With zero = 0 → pcwrite = 0; back to FETCH after 3 cycles.
- jal → states 0,1,10,8,0; pcwrite = 1 in JAL; regwrite = 1 in ALUWB; immsrc = 11.
- Opcode 1111111 with HALT_ON_ILLEGAL = 1 → state = 11, halted = 1, no enables for 20 cycles. With HALT_ON_ILLEGAL = 0 → returns to FETCH.
- MC_MEMREADY_EN defined: memready held low 3 cycles in FETCH → state stays 0, irwrite = 0; memready = 1 → irwrite = 1, next state DECODE.
